// File: rtl/sop_sweep_ctrl.sv
// Sequencer that sweeps a 3-input SOP evaluator through vectors 000..111,
// captures its truth table and scores it against an expected mask.
module sop_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXPECT = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic       pass,
  output logic [3:0] nbad,
  output logic [2:0] first_bad,
  output logic [1:0] fsm_state
);

  // Handshake: start is a level sampled only in IDLE (abort has priority);
  // done is a one-cycle pulse, and pass/nbad/first_bad/tt hold until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time every vector goes straight to its sample cycle.
  localparam state_t VEC_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       go;
  logic       mismatch;

  assign go       = start && !abort;
  assign mismatch = (f != EXPECT[idx]);
  assign x        = idx[2];
  assign y        = idx[1];
  assign z        = idx[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = VEC_STATE;
      S_SETTLE: begin
        if (abort)                    state_nxt = S_IDLE;
        else if (cnt == SETTLE_LAST)  state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)             state_nxt = S_IDLE;
        else if (idx == 3'd7)  state_nxt = S_DONE;
        else                   state_nxt = VEC_STATE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_SETTLE) || (state == S_SAMPLE);
    done      = (state == S_DONE);
    fsm_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 3'd0;
      cnt       <= 4'd0;
      tt        <= 8'd0;
      nbad      <= 4'd0;
      first_bad <= 3'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            tt        <= 8'd0;
            nbad      <= 4'd0;
            first_bad <= 3'd0;
            pass      <= 1'b0;
            idx       <= 3'd0;
            cnt       <= 4'd0;
          end
        end
        S_SETTLE: begin
          if (abort) idx <= 3'd0;
          else       cnt <= cnt + 4'd1;
        end
        S_SAMPLE: begin
          if (abort) begin
            idx <= 3'd0;
          end else begin
            tt[idx] <= f;
            if (mismatch) begin
              nbad <= nbad + 4'd1;
              // nbad still zero means this is the sweep's first mismatch.
              if (nbad == 4'd0) first_bad <= idx;
            end
            if (idx != 3'd7) begin
              idx <= idx + 3'd1;
              cnt <= 4'd0;
            end
          end
        end
        S_DONE: begin
          idx <= 3'd0;
          if (!abort) pass <= (nbad == 4'd0);
        end
        default: idx <= 3'd0;
      endcase
    end
  end

endmodule
